// File: rtl/axi4_lite_write_master.sv
// AXI4-Lite write-channel initiator with a one-entry posted-write buffer.
// Store requests become AW/W/B transactions, strictly in order, with at most
// one transaction on the bus and at most one request waiting behind it.
module axi4_lite_write_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_req,
   output logic                  write_ready,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [3:0]            write_strb,
   output logic                  write_done,
   output logic                  write_err,
   output logic                  write_idle,
   output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic                  M_AXI_AWVALID,
   input  logic                  M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic [3:0]            M_AXI_WSTRB,
   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   input  logic [1:0]            M_AXI_BRESP,
   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  bready_q, bready_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  ready_q, ready_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
   logic [3:0]            pend_strb_q, pend_strb_d;

   logic accept, aw_hs, w_hs, b_hs;
   logic start_req, start_pend, load_pend;

   assign accept = write_req && ready_q;
   assign aw_hs  = awvalid_q && M_AXI_AWREADY;
   assign w_hs   = wvalid_q && M_AXI_WREADY;
   assign b_hs   = bready_q && M_AXI_BVALID;

   // Next-state: channel tracking, pending buffer, and transaction launch
   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      pend_vld_d  = pend_vld_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      pend_strb_d = pend_strb_q;
      start_req   = 1'b0;
      start_pend  = 1'b0;
      load_pend   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) start_req = 1'b1;
         end
         S_SEND: begin
            // AW and W retire independently; VALID drops the cycle after its handshake
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d  = S_RESP;
               bready_d = 1'b1;
            end
            if (accept) load_pend = 1'b1;
         end
         S_RESP: begin
            if (b_hs) begin
               done_d   = 1'b1;
               err_d    = |M_AXI_BRESP;
               bready_d = 1'b0;
               // Chain straight into the next store with no IDLE bubble
               if (pend_vld_q)  start_pend = 1'b1;
               else if (accept) start_req  = 1'b1;
               else             state_d    = S_IDLE;
            end else if (accept) begin
               load_pend = 1'b1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
         end
      endcase

      if (start_req || start_pend) begin
         state_d   = S_SEND;
         awvalid_d = 1'b1;
         wvalid_d  = 1'b1;
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end
      if (start_req) begin
         awaddr_d = write_addr;
         wdata_d  = write_data;
         wstrb_d  = write_strb;
      end
      if (start_pend) begin
         awaddr_d   = pend_addr_q;
         wdata_d    = pend_data_q;
         wstrb_d    = pend_strb_q;
         pend_vld_d = 1'b0;
      end
      if (load_pend) begin
         pend_vld_d  = 1'b1;
         pend_addr_d = write_addr;
         pend_data_d = write_data;
         pend_strb_d = write_strb;
      end

      // write_ready is registered: it reflects buffer occupancy of the next cycle
      ready_d = !pend_vld_d;
   end

   // State and output registers, synchronous reset abandons any transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ready_q     <= 1'b1;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         pend_strb_q <= '0;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         done_q      <= done_d;
         err_q       <= err_d;
         ready_q     <= ready_d;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         pend_strb_q <= pend_strb_d;
      end
   end

   assign write_ready   = ready_q;
   assign write_done    = done_q;
   assign write_err     = err_q;
   assign write_idle    = (state_q == S_IDLE) && !pend_vld_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_axi4_lite_write_master.sv
// Bench for axi4_lite_write_master: table of stores with per-transaction slave
// timing, a scoreboard checking AW/W/B in order, and hand sequences for
// exact timing, back-to-back buffering and mid-transaction reset.
module tb_axi4_lite_write_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_req;
   logic        write_ready;
   logic [31:0] write_addr;
   logic [31:0] write_data;
   logic [3:0]  write_strb;
   logic        write_done, write_err, write_idle;
   logic [31:0] M_AXI_AWADDR;
   logic        M_AXI_AWVALID, M_AXI_AWREADY;
   logic [31:0] M_AXI_WDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY;

   axi4_lite_write_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .write_req(write_req), .write_ready(write_ready),
      .write_addr(write_addr), .write_data(write_data), .write_strb(write_strb),
      .write_done(write_done), .write_err(write_err), .write_idle(write_idle),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
      .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
      .M_AXI_BREADY(M_AXI_BREADY)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  bresp;
      int          aw_dly;
      int          w_dly;
      int          b_dly;
      logic        exp_err;
      int          exp_aw_cyc;
      int          exp_w_cyc;
   } vec_t;

   vec_t vecs[8];
   vec_t cfg_q[$];
   vec_t exp_aw_q[$];
   vec_t exp_w_q[$];
   vec_t exp_b_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [1:0] br, input int awd, input int wd, input int bd,
                               input logic e, input int awc, input int wc);
      vec_t v;
      v.addr = a; v.data = d; v.strb = s; v.bresp = br;
      v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd;
      v.exp_err = e; v.exp_aw_cyc = awc; v.exp_w_cyc = wc;
      return v;
   endfunction

   // ---------------- slave model ----------------
   vec_t cur;
   logic in_txn = 1'b0, aw_got = 1'b0, w_got = 1'b0;
   logic p_aw = 1'b0, p_w = 1'b0, p_b = 1'b0, rst_at_edge;
   int   aw_cnt = 0, w_cnt = 0, b_cnt = 0;

   initial begin
      M_AXI_AWREADY = 1'b0;
      M_AXI_WREADY  = 1'b0;
      M_AXI_BVALID  = 1'b0;
      M_AXI_BRESP   = 2'b00;
      forever begin
         @(posedge clk);
         rst_at_edge = rst;
         #1;
         if (rst_at_edge) begin
            in_txn = 1'b0; aw_got = 1'b0; w_got = 1'b0;
            p_aw = 1'b0; p_w = 1'b0; p_b = 1'b0;
            M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
         end else begin
            if (p_aw) aw_got = 1'b1;
            if (p_w)  w_got  = 1'b1;
            if (p_b) begin
               in_txn = 1'b0;
               M_AXI_BVALID = 1'b0;
            end
            if (!in_txn && (M_AXI_AWVALID || M_AXI_WVALID)) begin
               if (cfg_q.size() > 0) cur = cfg_q.pop_front();
               else cur = mk(0, 0, 0, 2'b00, 0, 0, 0, 1'b0, 1, 1);
               in_txn = 1'b1; aw_got = 1'b0; w_got = 1'b0;
               aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end
            M_AXI_AWREADY = 1'b0;
            if (in_txn && M_AXI_AWVALID && !aw_got) begin
               M_AXI_AWREADY = (aw_cnt >= cur.aw_dly);
               aw_cnt++;
            end
            M_AXI_WREADY = 1'b0;
            if (in_txn && M_AXI_WVALID && !w_got) begin
               M_AXI_WREADY = (w_cnt >= cur.w_dly);
               w_cnt++;
            end
            if (in_txn && aw_got && w_got && !M_AXI_BVALID) begin
               if (b_cnt >= cur.b_dly) begin
                  M_AXI_BVALID = 1'b1;
                  M_AXI_BRESP  = cur.bresp;
               end else begin
                  b_cnt++;
               end
            end
            p_aw = M_AXI_AWVALID && M_AXI_AWREADY;
            p_w  = M_AXI_WVALID && M_AXI_WREADY;
            p_b  = M_AXI_BVALID && M_AXI_BREADY;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   logic        pv_aw = 1'b0, pv_w = 1'b0;
   logic [31:0] p_awaddr, p_wdata;
   logic [3:0]  p_wstrb;
   int          aw_cyc = 0, w_cyc = 0;

   always @(negedge clk) begin
      vec_t e;
      if (rst) begin
         pv_aw = 1'b0; pv_w = 1'b0; aw_cyc = 0; w_cyc = 0;
      end else begin
         if (pv_aw) begin
            chk("awvalid_hold", M_AXI_AWVALID, 1);
            chk("awaddr_stable", M_AXI_AWADDR, p_awaddr);
         end
         if (pv_w) begin
            chk("wvalid_hold", M_AXI_WVALID, 1);
            chk("wdata_stable", M_AXI_WDATA, p_wdata);
            chk("wstrb_stable", M_AXI_WSTRB, p_wstrb);
         end
         if (M_AXI_AWVALID) aw_cyc++;
         if (M_AXI_WVALID)  w_cyc++;
         if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            if (exp_aw_q.size() == 0) fail("aw_unexpected");
            else begin
               e = exp_aw_q.pop_front();
               chk("awaddr", M_AXI_AWADDR, e.addr);
               chk("aw_valid_cycles", aw_cyc, e.exp_aw_cyc);
            end
            aw_cyc = 0;
         end
         if (M_AXI_WVALID && M_AXI_WREADY) begin
            if (exp_w_q.size() == 0) fail("w_unexpected");
            else begin
               e = exp_w_q.pop_front();
               chk("wdata", M_AXI_WDATA, e.data);
               chk("wstrb", M_AXI_WSTRB, e.strb);
               chk("w_valid_cycles", w_cyc, e.exp_w_cyc);
            end
            w_cyc = 0;
         end
         if (write_done) begin
            if (exp_b_q.size() == 0) fail("done_unexpected");
            else begin
               e = exp_b_q.pop_front();
               chk("write_err", write_err, e.exp_err);
            end
         end
         pv_aw = M_AXI_AWVALID && !M_AXI_AWREADY;
         pv_w  = M_AXI_WVALID && !M_AXI_WREADY;
         p_awaddr = M_AXI_AWADDR;
         p_wdata  = M_AXI_WDATA;
         p_wstrb  = M_AXI_WSTRB;
      end
   end

   // ---------------- driver tasks (called aligned at posedge+1) ----------------
   task automatic do_req(input vec_t v);
      int t = 0;
      while (!write_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) fail("req_ready_timeout");
      write_req = 1'b1; write_addr = v.addr; write_data = v.data; write_strb = v.strb;
      cfg_q.push_back(v);
      exp_aw_q.push_back(v);
      exp_w_q.push_back(v);
      exp_b_q.push_back(v);
      @(posedge clk); #1;
      write_req = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(write_idle && exp_b_q.size() == 0) && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 500) fail("idle_timeout");
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic clear_sb();
      cfg_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); exp_b_q.delete();
   endtask

   initial begin
      int t;
      logic seen;
      // addr, data, strb, bresp, aw_dly, w_dly, b_dly, exp_err, aw_cyc, w_cyc
      vecs[0] = mk(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0, 0, 1'b0, 1, 1);
      vecs[1] = mk(32'h1000_0008, 32'h0BAD_F00D, 4'hF, 2'b00, 3, 0, 0, 1'b0, 4, 1);
      vecs[2] = mk(32'h1000_000C, 32'hCAFE_0001, 4'h3, 2'b00, 0, 2, 1, 1'b0, 1, 3);
      vecs[3] = mk(32'h2000_0000, 32'h1234_5678, 4'hF, 2'b10, 0, 0, 0, 1'b1, 1, 1);
      vecs[4] = mk(32'h2000_0004, 32'h8765_4321, 4'hC, 2'b11, 1, 1, 2, 1'b1, 2, 2);
      vecs[5] = mk(32'h2000_0008, 32'hA5A5_5A5A, 4'h5, 2'b00, 0, 0, 0, 1'b0, 1, 1);
      vecs[6] = mk(32'h3000_0010, 32'hFFFF_0000, 4'h1, 2'b01, 2, 1, 3, 1'b1, 3, 2);
      vecs[7] = mk(32'hFFFF_FFFC, 32'h0000_0001, 4'h8, 2'b00, 1, 3, 0, 1'b0, 2, 4);

      rst = 1'b1; write_req = 1'b0; write_addr = '0; write_data = '0; write_strb = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_awvalid", M_AXI_AWVALID, 0);
      chk("rst_wvalid", M_AXI_WVALID, 0);
      chk("rst_bready", M_AXI_BREADY, 0);
      chk("rst_awaddr", M_AXI_AWADDR, 0);
      chk("rst_wdata", M_AXI_WDATA, 0);
      chk("rst_wstrb", M_AXI_WSTRB, 0);
      chk("rst_done", write_done, 0);
      chk("rst_ready", write_ready, 1);
      chk("rst_idle", write_idle, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Exact timing of a single store with an always-ready slave
      do_req(vecs[0]);
      @(negedge clk);
      chk("t1_c1_awvalid", M_AXI_AWVALID, 1);
      chk("t1_c1_wvalid", M_AXI_WVALID, 1);
      chk("t1_c1_idle", write_idle, 0);
      @(negedge clk);
      chk("t1_c2_bready", M_AXI_BREADY, 1);
      chk("t1_c2_awvalid", M_AXI_AWVALID, 0);
      chk("t1_c2_done", write_done, 0);
      @(negedge clk);
      chk("t1_c3_done", write_done, 1);
      chk("t1_c3_err", write_err, 0);
      chk("t1_c3_idle", write_idle, 1);
      chk("t1_c3_bready", M_AXI_BREADY, 0);
      @(posedge clk); #1;
      wait_idle();

      // Table: varied slave timing and responses, one store at a time
      for (int i = 0; i < 8; i++) begin
         do_req(vecs[i]);
         wait_idle();
      end

      // Back-to-back with buffered second store and an ignored third
      do_req(mk(32'h0000_0100, 32'h1111_1111, 4'hF, 2'b00, 0, 0, 4, 1'b0, 1, 1));
      do_req(mk(32'h0000_0104, 32'h2222_2222, 4'hF, 2'b00, 0, 0, 0, 1'b0, 1, 1));
      write_req = 1'b1; write_addr = 32'h0000_0108; write_data = 32'h3333_3333; write_strb = 4'hF;
      @(negedge clk);
      chk("b2b_ready_low", write_ready, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      write_req = 1'b0;
      t = 0; seen = 1'b0;
      while (!seen && t < 50) begin
         @(negedge clk);
         if (write_done) seen = 1'b1;
         else chk("b2b_ready_held_low", write_ready, 0);
         t++;
      end
      if (!seen) fail("b2b_done_timeout");
      else begin
         chk("b2b_second_awvalid", M_AXI_AWVALID, 1);
         chk("b2b_second_awaddr", M_AXI_AWADDR, 32'h0000_0104);
         chk("b2b_ready_back", write_ready, 1);
      end
      @(posedge clk); #1;
      wait_idle();

      // Reset while AW is stalled
      do_req(mk(32'h4000_0000, 32'h5555_AAAA, 4'hF, 2'b00, 20, 0, 0, 1'b0, 21, 1));
      @(negedge clk);
      chk("rs_awvalid_before", M_AXI_AWVALID, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      clear_sb();
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rs_awvalid", M_AXI_AWVALID, 0);
      chk("rs_wvalid", M_AXI_WVALID, 0);
      chk("rs_bready", M_AXI_BREADY, 0);
      chk("rs_ready", write_ready, 1);
      chk("rs_idle", write_idle, 1);
      chk("rs_done", write_done, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      do_req(mk(32'h4000_0040, 32'h7777_8888, 4'h6, 2'b00, 1, 0, 1, 1'b0, 2, 1));
      wait_idle();

      chk("sb_aw_empty", exp_aw_q.size(), 0);
      chk("sb_w_empty", exp_w_q.size(), 0);
      chk("sb_b_empty", exp_b_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axi4_lite_write_master.md
Name: axi4_lite_write_master

Overview:
AXI4-Lite write-channel initiator. It converts simple processor/DMA store requests into AW/W/B transactions toward the interconnect slaves. A one-entry posted-write buffer lets the requester issue a second store while the first is still in flight. Completion status from BRESP is reported back to the requester per transaction, in order.

Parameters:
ADDR_WIDTH, 32, width of the request address and M_AXI_AWADDR.
DATA_WIDTH, 32, width of the request data and M_AXI_WDATA; the strobe is fixed at 4 bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
write_req  input  1  request valid; accepted when write_req && write_ready.
write_ready  output  1  request can be accepted (pending buffer empty).
write_addr  input  ADDR_WIDTH  store address.
write_data  input  DATA_WIDTH  store data.
write_strb  input  4  byte enables.
write_done  output  1  one-cycle pulse per completed B handshake.
write_err  output  1  valid with write_done; 1 if BRESP != 2'b00.
write_idle  output  1  no active and no pending transaction (fence support).
M_AXI_AWADDR  output  ADDR_WIDTH  write address.
M_AXI_AWVALID  output  1  address valid.
M_AXI_AWREADY  input  1  slave accepts address.
M_AXI_WDATA  output  DATA_WIDTH  write data.
M_AXI_WSTRB  output  4  write strobes.
M_AXI_WVALID  output  1  data valid.
M_AXI_WREADY  input  1  slave accepts data.
M_AXI_BRESP  input  2  write response.
M_AXI_BVALID  input  1  response valid.
M_AXI_BREADY  output  1  master accepts response.

Behaviour:
- Reset (synchronous, rst high at a clk edge): state=IDLE; AWVALID=WVALID=BREADY=0; AWADDR/WDATA/WSTRB=0; write_done=write_err=0; pending empty; write_ready=1; write_idle=1.
- Reset mid-transaction abandons the transaction and drops all VALIDs the next cycle. Slaves share the same rst.
- All outputs are registered except write_idle, which is decoded from registered state only.
- States:
  - IDLE: no transaction.
  - SEND: AW and/or W still outstanding.
  - RESP: BREADY=1, waiting for BVALID.
- Request acceptance:
  - IDLE: the request loads the active registers directly. Next cycle: state=SEND, AWVALID=WVALID=1, AWADDR/WDATA/WSTRB=request values. Latency from request to VALID is 1 cycle.
  - Not IDLE: the request loads the pending buffer and write_ready=0 from the next cycle.
- SEND:
  - AW and W are tracked independently with aw_done/w_done flags.
  - AWVALID stays high with AWADDR stable until a cycle with AWVALID && AWREADY, then drops the next cycle. W behaves the same.
  - Handshakes may complete in the same cycle or in either order.
  - VALID never depends combinationally on READY.
  - When both handshakes are done (including both in the same cycle), the next state is RESP with BREADY=1.
- RESP:
  - On BVALID && BREADY: write_done=1 and write_err=(BRESP!=2'b00) the next cycle, for one cycle. BREADY drops the next cycle.
  - SLVERR and DECERR both set write_err.
- Transition after the B handshake:
  - Pending valid: it moves to active, state=SEND with both VALIDs high the next cycle (no IDLE gap), pending cleared, write_ready=1.
  - Pending empty and a request accepted in the same cycle: that request loads active directly and goes to SEND.
  - Otherwise: IDLE.
- Ordering: strictly in order. At most one AXI transaction is outstanding; at most one request is buffered.
- write_req while write_ready=0 is ignored; the requester must hold it.
- write_idle = (state==IDLE) && pending empty.

Test Plan:
1. Single write, slave ready: req addr 0x10000004, data 0xDEADBEEF, strb 0xF at cycle 0; AWREADY=WREADY=1 -> AW/W VALID and handshake in cycle 1; BREADY cycle 2; slave BVALID cycle 2, BRESP 00 -> write_done=1, write_err=0 at cycle 3; write_idle=1 at cycle 3.
2. AW delayed: WREADY=1, AWREADY low for 3 cycles -> WVALID drops after cycle 1; AWVALID held 4 cycles with AWADDR constant; exactly one B handshake and one done pulse.
3. W delayed: AWREADY=1, WREADY after 2 cycles -> symmetric result; WDATA/WSTRB stable while WVALID=1.
4. Back-to-back: reqs at cycles 0 (0x100/0x11111111) and 1 (0x104/0x22222222); slave BVALID delayed 4 cycles -> write_ready=0 from cycle 2 until the first B handshake; second AWVALID the cycle after that handshake; two done pulses in order; a third req while write_ready=0 has no effect.
5. Error response: BRESP=2'b10, then a second write with BRESP=2'b11 -> write_err=1 on both done pulses; a following write with BRESP=00 -> write_err=0.
6. Reset mid-SEND with AWREADY=0 -> next cycle AWVALID=WVALID=BREADY=0, write_ready=1, write_idle=1, no write_done; a new request afterwards completes normally.
